// File: rtl/dicd_result_serializer_pkg.sv
// Shared types for the DICD result serializer. Word count depends on DICD_SER_CHECKSUM_EN
// (defined: trailing XOR checksum word, NW=6; undefined: NW=5).
package dicd_result_serializer_pkg;

  localparam int DICD_SER_W = 16;
`ifdef DICD_SER_CHECKSUM_EN
  localparam int DICD_SER_NW = 6;
`else
  localparam int DICD_SER_NW = 5;
`endif

  localparam int FIELD_W = 14;
  localparam int ANG_W   = 11;

  typedef logic [FIELD_W-1:0] phi_t;
  typedef logic [FIELD_W-1:0] gamma_t;
  typedef logic [FIELD_W-1:0] mag_t;
  typedef logic [ANG_W-1:0]   ang_t;
  typedef logic [FIELD_W-1:0] lambda_t;

  typedef struct packed {
    phi_t    phi;
    gamma_t  gamma;
    mag_t    mag;
    ang_t    ang;
    lambda_t lambda;
  } dicd_result_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/dicd_result_serializer_fifo.sv
// Tuple FIFO for the result serializer; exposes the head and the entry behind it
// combinationally so the serializer can chain tuples without a bubble.
module dicd_result_fifo
  import dicd_result_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  dicd_result_t  wr_data_i,
  input  logic          pop_i,
  output dicd_result_t  head_o,
  output dicd_result_t  next_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  dicd_result_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign count_o = count_q;
  assign push_s  = push_i && !full_o;
  assign pop_s   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign next_o  = mem_q[rd_ptr_q + AW'(1)];

  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    count_d  = count_q + CW'(push_s) - CW'(pop_s);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only occupied entries are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dicd_result_serializer.sv
// DICD result serializer: buffers result tuples and streams them as sign-extended words.
// DICD_SER_CHECKSUM_EN appends an XOR checksum word carrying out_eof.
module dicd_result_serializer
  import dicd_result_serializer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int OUT_W = DICD_SER_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [13:0]      in_phi,
  input  logic [13:0]      in_gamma,
  input  logic [13:0]      in_mag,
  input  logic [10:0]      in_ang,
  input  logic [13:0]      in_lambda,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sof,
  output logic             out_eof,
  output logic [15:0]      frame_cnt
);

  localparam int CW = $clog2(DEPTH + 1);

  ser_state_e    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic          out_sof_q, out_sof_d;
  logic          out_eof_q, out_eof_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;

  dicd_result_t  in_tuple_s, head_s, next_s, chain_s;
  logic          fifo_full_s, fifo_empty_s;
  logic [CW-1:0] fifo_count_s;
  logic          push_s, pop_s, eof_hs_s, adv_s, has_next_s, two_held_s;

  function automatic logic [OUT_W-1:0] word_of(input dicd_result_t t, input logic [2:0] idx);
    logic [OUT_W-1:0] w_phi, w_gamma, w_mag, w_ang, w_lambda, w;
    w_phi    = {{(OUT_W-FIELD_W){t.phi[FIELD_W-1]}}, t.phi};
    w_gamma  = {{(OUT_W-FIELD_W){t.gamma[FIELD_W-1]}}, t.gamma};
    w_mag    = {{(OUT_W-FIELD_W){t.mag[FIELD_W-1]}}, t.mag};
    w_ang    = {{(OUT_W-ANG_W){t.ang[ANG_W-1]}}, t.ang};
    w_lambda = {{(OUT_W-FIELD_W){t.lambda[FIELD_W-1]}}, t.lambda};
    case (idx)
      3'd0:    w = w_phi;
      3'd1:    w = w_gamma;
      3'd2:    w = w_mag;
      3'd3:    w = w_ang;
      3'd4:    w = w_lambda;
`ifdef DICD_SER_CHECKSUM_EN
      3'd5:    w = w_phi ^ w_gamma ^ w_mag ^ w_ang ^ w_lambda;
`endif
      default: w = {OUT_W{1'b0}};
    endcase
    return w;
  endfunction

  assign in_tuple_s = '{phi: in_phi, gamma: in_gamma, mag: in_mag, ang: in_ang, lambda: in_lambda};
  assign in_ready   = !rst && !fifo_full_s;
  assign push_s     = in_valid && in_ready;
  assign eof_hs_s   = out_valid_q && out_ready && out_eof_q;
  assign adv_s      = !out_valid_q || out_ready;
  // A tuple pushed while the head finishes becomes the new head; take it from the input.
  assign two_held_s = (fifo_count_s > CW'(1));
  assign has_next_s = two_held_s || push_s;
  assign chain_s    = two_held_s ? next_s : in_tuple_s;

  dicd_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push_s),
    .wr_data_i (in_tuple_s),
    .pop_i     (pop_s),
    .head_o    (head_s),
    .next_o    (next_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) state_d = ST_SEND;
        else               state_d = ST_IDLE;
      end
      ST_SEND: begin
        if (eof_hs_s && !has_next_s) state_d = ST_IDLE;
        else                         state_d = ST_SEND;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // idx_q is the index of the word loaded on the next advance.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sof_d   = out_sof_q;
    out_eof_d   = out_eof_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    pop_s       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        out_sof_d   = 1'b0;
        out_eof_d   = 1'b0;
        idx_d       = 3'd0;
      end
      ST_SEND: begin
        if (eof_hs_s) begin
          pop_s       = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          if (has_next_s) begin
            out_valid_d = 1'b1;
            out_data_d  = word_of(chain_s, 3'd0);
            out_sof_d   = 1'b1;
            out_eof_d   = 1'b0;
            idx_d       = 3'd1;
          end else begin
            out_valid_d = 1'b0;
            out_sof_d   = 1'b0;
            out_eof_d   = 1'b0;
            idx_d       = 3'd0;
          end
        end else if (adv_s) begin
          out_valid_d = 1'b1;
          out_data_d  = word_of(head_s, idx_q);
          out_sof_d   = (idx_q == 3'd0);
          out_eof_d   = (idx_q == 3'(DICD_SER_NW - 1));
          idx_d       = idx_q + 3'd1;
        end else begin
          out_valid_d = out_valid_q;
          out_data_d  = out_data_q;
          out_sof_d   = out_sof_q;
          out_eof_d   = out_eof_q;
          idx_d       = idx_q;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        idx_d       = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= {OUT_W{1'b0}};
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      idx_q       <= 3'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dicd_result_serializer.sv
// Randomized bench for dicd_result_serializer against a word-queue reference model.
module tb_dicd_result_serializer;
  import dicd_result_serializer_pkg::*;

  localparam int DEPTH = 2;
  localparam int NW    = DICD_SER_NW;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_phi, in_gamma, in_mag, in_lambda;
  logic [10:0] in_ang;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sof, out_eof;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  dicd_result_serializer #(
    .DEPTH (DEPTH),
    .OUT_W (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_phi    (in_phi),
    .in_gamma  (in_gamma),
    .in_mag    (in_mag),
    .in_ang    (in_ang),
    .in_lambda (in_lambda),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .frame_cnt (frame_cnt)
  );

  typedef struct {
    logic [15:0] d;
    logic        sof;
    logic        eof;
  } exp_t;

  exp_t exp_q[$];
  int   occ      = 0;
  int   done_cnt = 0;
  bit   rst_prev = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expand the tuple on the input pins into its expected word sequence.
  task automatic model_push();
    int          v [5];
    logic [15:0] ck;
    exp_t        e;
    v[0] = $signed(in_phi);
    v[1] = $signed(in_gamma);
    v[2] = $signed(in_mag);
    v[3] = $signed(in_ang);
    v[4] = $signed(in_lambda);
    ck = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      e.d   = v[i][15:0];
      e.sof = (i == 0);
      e.eof = (i == NW - 1);
      ck    = ck ^ e.d;
      exp_q.push_back(e);
    end
`ifdef DICD_SER_CHECKSUM_EN
    e.d   = ck;
    e.sof = 1'b0;
    e.eof = 1'b1;
    exp_q.push_back(e);
`endif
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (rst_prev) begin
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sof_eof", 32'({out_sof, out_eof}), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      end
      check("rst_in_ready", 32'(in_ready), 32'd0);
      exp_q.delete();
      occ      = 0;
      done_cnt = 0;
      rst_prev = 1'b1;
    end else begin
      rst_prev = 1'b0;
      check("in_ready", 32'(in_ready), 32'(occ < DEPTH));
      check("frame_cnt", 32'(frame_cnt), 32'(done_cnt & 16'hFFFF));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_word", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sof", 32'(out_sof), 32'(e.sof));
          check("out_eof", 32'(out_eof), 32'(e.eof));
          if (e.eof) begin
            done_cnt++;
            occ--;
          end
        end
      end
      if (in_valid && in_ready) begin
        model_push();
        occ++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tuple(input logic [13:0] p, input logic [13:0] g, input logic [13:0] m,
                           input logic [10:0] a, input logic [13:0] l);
    in_phi    = p;
    in_gamma  = g;
    in_mag    = m;
    in_ang    = a;
    in_lambda = l;
  endtask

  task automatic rand_tuple();
    set_tuple(14'($urandom), 14'($urandom), 14'($urandom), 11'($urandom), 14'($urandom));
  endtask

  logic [15:0] t1_words [5] = '{16'h0100, 16'hFF00, 16'h0080, 16'hFC00, 16'h1FFF};
  int          hs;
  bit          acc;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    set_tuple(14'h0, 14'h0, 14'h0, 11'h0, 14'h0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Known tuple: latency of two edges, then the documented word values.
    set_tuple(14'h0100, 14'h3F00, 14'h0080, 11'h400, 14'h1FFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_edge0_valid", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    check("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_word", 32'(out_data), 32'(t1_words[i]));
      tick();
    end
    tick();
    @(negedge clk);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    tick();

    // Back-pressure after gamma: mag word must hold.
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'h0080);
      tick();
    end
    out_ready = 1'b1;
    repeat (8) tick();

    // Fill past capacity with the sink stalled, then release.
    out_ready = 1'b0;
    rand_tuple();
    in_valid = 1'b1;
    tick();
    rand_tuple();
    tick();
    rand_tuple();
    tick();
    @(negedge clk);
    check("full_in_ready", 32'(in_ready), 32'd0);
    repeat (3) tick();
    out_ready = 1'b1;
    hs = 0;
    for (int c = 0; c < 40 && hs < 3 * NW; c++) begin
      @(negedge clk);
      check("no_bubble", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) hs++;
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
    end
    check("b2b_words", 32'(hs), 32'(3 * NW));
    in_valid = 1'b0;
    repeat (3) tick();

    // Reset while the third word is presented.
    rand_tuple();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    check("post_rst_frame", 32'(frame_cnt), 32'd0);
    rand_tuple();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("post_rst_sof", 32'({out_valid, out_sof}), 32'd3);
    repeat (8) tick();

    // Random traffic: a free-flowing phase, then random back-pressure.
    for (int c = 0; c < 1200; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_tuple();
      out_ready = (c < 300) ? 1'b1 : ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
